// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions: polynomial/seed constants, framer FSM states and
// the serial MSB-first byte update used by both the RTL and regression models.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_XOROUT = 16'h0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    CRC_HI = 3'd2,
    CRC_LO = 3'd3,
    WAIT   = 3'd4
  } crc_fsm_t;

  // Eight shift steps, bit 7 of the byte first; x^16 is implicit in poly.
  function automatic logic [15:0] crc16_upd8(input logic [15:0] c,
                                             input logic [7:0]  b,
                                             input logic [15:0] poly);
    logic [15:0] acc;
    logic        fb;
    acc = c;
    for (int i = 7; i >= 0; i--) begin
      fb  = acc[15] ^ b[i];
      acc = {acc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    end
    return acc;
  endfunction

endpackage

// File: rtl/crc16_byte_update.sv
// Combinational one-byte CRC-16 step; also reused by the CRC_16_parallel
// regression model.
module crc16_byte_update
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  // Next CRC after folding in one byte.
  always_comb begin
    crc_out = crc16_upd8(crc_in, data_in, POLY);
  end

endmodule

// File: rtl/crc16_frame_appender.sv
// Byte-stream framer: forwards payload bytes through one output register and
// appends the per-frame CRC-16 as a high byte then a low byte (m_last).
module crc16_frame_appender
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY   = CRC16_POLY,
  parameter logic [15:0] INIT   = CRC16_INIT,
  parameter logic [15:0] XOROUT = CRC16_XOROUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] crc_value,
  output logic        crc_done
);

  crc_fsm_t    state_r;
  logic [15:0] crc_r;
  logic [15:0] crc_seed_s;
  logic [15:0] crc_next_s;
  logic [15:0] crc_fin_s;
  logic        out_free_s;
  logic        accept_s;

  // Handshake qualifiers and CRC operands; a new frame always starts from INIT.
  always_comb begin
    out_free_s = !m_valid || m_ready;
    s_ready    = out_free_s && ((state_r == IDLE) || (state_r == DATA));
    accept_s   = s_valid && s_ready;
    crc_seed_s = (state_r == IDLE) ? INIT : crc_r;
    crc_fin_s  = crc_r ^ XOROUT;
  end

  crc16_byte_update #(
    .POLY(POLY)
  ) u_byte_update (
    .crc_in (crc_seed_s),
    .data_in(s_data),
    .crc_out(crc_next_s)
  );

  // Framer FSM with the registered output stage and CRC result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      crc_r     <= INIT;
      m_data    <= 8'h00;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      crc_value <= 16'h0000;
      crc_done  <= 1'b0;
    end else begin
      crc_done <= 1'b0;
      // An accepted byte empties the register unless a state below refills it.
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        m_valid <= m_valid;
        m_last  <= m_last;
      end
      case (state_r)
        IDLE, DATA: begin
          if (accept_s) begin
            crc_r   <= crc_next_s;
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            state_r <= s_last ? CRC_HI : DATA;
          end else begin
            state_r <= state_r;
          end
        end
        CRC_HI: begin
          if (out_free_s) begin
            m_data  <= crc_fin_s[15:8];
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            state_r <= CRC_LO;
          end else begin
            state_r <= CRC_HI;
          end
        end
        CRC_LO: begin
          if (out_free_s) begin
            m_data  <= crc_fin_s[7:0];
            m_valid <= 1'b1;
            m_last  <= 1'b1;
            state_r <= WAIT;
          end else begin
            state_r <= CRC_LO;
          end
        end
        WAIT: begin
          if (m_valid && m_ready) begin
            crc_value <= crc_fin_s;
            crc_done  <= 1'b1;
            crc_r     <= INIT;
            state_r   <= IDLE;
          end else begin
            state_r <= WAIT;
          end
        end
        default: begin
          crc_r   <= INIT;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_frame_appender.sv
// Randomised self-checking bench: scoreboard of expected output bytes and CRCs
// built from a polynomial-division reference model.
module tb_crc16_frame_appender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [15:0] crc_value;
  logic        crc_done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int out_cnt = 0;

  logic [7:0]  exp_data_q[$];
  logic        exp_last_q[$];
  logic [15:0] exp_crc_q[$];
  bit          vpat_q[$];

  bit         rand_ready = 1'b0;
  bit         tput_mode = 1'b0;
  bit         tput_seen = 1'b0;
  bit         trailer_pend = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] data_prev;
  logic       last_prev;

  always #5 clk = ~clk;

  crc16_frame_appender dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .crc_value(crc_value),
    .crc_done (crc_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: CRC as long division of the whole frame, byte XORed into the top.
  function automatic logic [15:0] ref_crc(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[k]) begin
      c = c ^ {q[k], 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c ^ 16'h0000;
  endfunction

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev   = 1'b0;
      trailer_pend = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, data_prev);
        chk("hold_last", m_last, last_prev);
      end
      if (crc_done) begin
        done_cnt++;
        trailer_pend = 1'b0;
        if (exp_crc_q.size() == 0) chk("extra_crc_done", exp_crc_q.size(), 1);
        else chk("crc_value", crc_value, exp_crc_q.pop_front());
      end
      if (trailer_pend) chk("s_ready_trailer", s_ready, 0);
      if (m_valid && m_last) chk("s_ready_wait", s_ready, 0);
      if (s_valid && s_ready && s_last) trailer_pend = 1'b1;
      if (tput_mode && (tput_seen || m_valid)) begin
        tput_seen = 1'b1;
        vpat_q.push_back(m_valid);
      end
      if (m_valid && m_ready) begin
        out_cnt++;
        if (exp_data_q.size() == 0) chk("extra_byte", exp_data_q.size(), 1);
        else begin
          chk("m_data", m_data, exp_data_q.pop_front());
          chk("m_last", m_last, exp_last_q.pop_front());
        end
      end
      stall_prev = m_valid && !m_ready;
      data_prev  = m_data;
      last_prev  = m_last;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("s_ready_timeout", n, 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    s_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [7:0] q[$], input int gap_max);
    logic [15:0] c;
    c = ref_crc(q);
    foreach (q[k]) begin
      exp_data_q.push_back(q[k]);
      exp_last_q.push_back(1'b0);
    end
    exp_data_q.push_back(c[15:8]); exp_last_q.push_back(1'b0);
    exp_data_q.push_back(c[7:0]);  exp_last_q.push_back(1'b1);
    exp_crc_q.push_back(c);
    foreach (q[k]) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      send_byte(q[k], k == q.size() - 1);
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n > 0) #1;
    chk("done_count", done_cnt, target);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] f123[$];
    logic [7:0] fz[$];
    logic [7:0] fa[$];
    logic [7:0] fb[$];
    int o0;
    int d0;

    for (int i = 0; i < 9; i++) f123.push_back(8'h31 + 8'(i));
    fz.push_back(8'h00);

    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_crc_value", crc_value, 0);
    chk("rst_crc_done", crc_done, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;

    o0 = out_cnt;
    send_frame(f123, 0);
    wait_done(1);
    chk("t1_crc", crc_value, 16'h29B1);
    chk("t1_bytes", out_cnt - o0, 11);

    o0 = out_cnt;
    send_frame(fz, 0);
    wait_done(2);
    chk("t2_crc", crc_value, 16'hE1F0);
    chk("t2_bytes", out_cnt - o0, 3);

    send_frame(f123, 0);
    send_frame(fz, 0);
    wait_done(4);
    chk("t3_crc", crc_value, 16'hE1F0);

    rand_ready = 1'b1;
    send_frame(f123, 1);
    wait_done(5);
    chk("t4_crc", crc_value, 16'h29B1);
    rand_ready = 1'b0;

    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_data_q.push_back(f123[i]);
      exp_last_q.push_back(1'b0);
      send_byte(f123[i], 1'b0);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_m_valid", m_valid, 0);
    chk("t5_m_data", m_data, 0);
    chk("t5_m_last", m_last, 0);
    chk("t5_crc_value", crc_value, 0);
    chk("t5_crc_done", crc_done, 0);
    exp_data_q.delete();
    exp_last_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt, d0);
    send_frame(f123, 0);
    wait_done(d0 + 1);
    chk("t5_crc", crc_value, 16'h29B1);

    d0 = done_cnt;
    for (int i = 0; i < 5; i++) fa.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) fb.push_back(8'($urandom));
    vpat_q.delete();
    tput_seen = 1'b0;
    tput_mode = 1'b1;
    send_frame(fa, 0);
    send_frame(fb, 0);
    wait_done(d0 + 2);
    tput_mode = 1'b0;
    chk("t6_pattern_len", (vpat_q.size() >= 13) ? 13 : vpat_q.size(), 13);
    for (int i = 0; i < 13; i++) begin
      if (i < vpat_q.size()) chk("t6_valid_pattern", vpat_q[i], (i == 7) ? 0 : 1);
    end

    rand_ready = 1'b1;
    d0 = done_cnt;
    for (int f = 0; f < 15; f++) begin
      logic [7:0] fr[$];
      int len;
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
      send_frame(fr, 2);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_done(d0 + 15);
    rand_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("leftover_bytes", exp_data_q.size(), 0);
    chk("leftover_crcs", exp_crc_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
